// File: rtl/cmp_result_tracker_pkg.sv
// Shared types and helpers for the comparator result tracker.
package cmp_trk_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  typedef enum logic [2:0] {CAT_LT, CAT_GT, CAT_EQ, CAT_ERR, CAT_NONE} cat_t;

  // Saturating increment for a w-bit counter carried in a 32-bit container (w <= 31).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cmp_result_tracker_if.sv
// Sample stream and report handshake between comparator, tracker and status logic.
interface cmp_result_tracker_if #(parameter int CNT_W = 8);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             in_lesser;
  logic             in_greater;
  logic             in_equal;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] eq_run_max;
  logic [CNT_W-1:0] err_cnt;
  logic             rpt_valid;
  logic             rpt_ready;
  logic             busy;

  modport master (
    output start, in_valid, in_lesser, in_greater, in_equal, rpt_ready,
    input  in_ready, lt_cnt, gt_cnt, eq_cnt, eq_run_max, err_cnt, rpt_valid, busy
  );

  modport slave (
    input  start, in_valid, in_lesser, in_greater, in_equal, rpt_ready,
    output in_ready, lt_cnt, gt_cnt, eq_cnt, eq_run_max, err_cnt, rpt_valid, busy
  );
endinterface

// File: rtl/cmp_result_tracker_decode.sv
// Maps comparator flags to one category; CMP_TRK_ERR_CHECK_EN selects strict one-hot checking.
module cmp_flag_decode
  import cmp_trk_pkg::*;
(
  input  logic lesser,
  input  logic greater,
  input  logic equal,
  output cat_t cat
);

  always_comb begin
    cat = CAT_NONE;
`ifdef CMP_TRK_ERR_CHECK_EN
    case ({lesser, greater, equal})
      3'b100:  cat = CAT_LT;
      3'b010:  cat = CAT_GT;
      3'b001:  cat = CAT_EQ;
      default: cat = CAT_ERR;
    endcase
`else
    if (lesser)       cat = CAT_LT;
    else if (greater) cat = CAT_GT;
    else if (equal)   cat = CAT_EQ;
`endif
  end

endmodule

// File: rtl/cmp_result_tracker.sv
// Windowed comparator-result statistics with a held snapshot report.
// Optional macro CMP_TRK_ERR_CHECK_EN enables the non-one-hot error counter.
module cmp_result_tracker
  import cmp_trk_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
)
(
  input logic clk,
  input logic rst,
  cmp_result_tracker_if.slave bus
);

  localparam int IDX_W = $clog2(WINDOW + 1);

  state_t           state, state_n;
  cat_t             cat;
  logic [IDX_W-1:0] idx;
  logic             ready, accept, last;
  logic [CNT_W-1:0] lt_acc, gt_acc, eq_acc, run_cur, run_max;
  logic [CNT_W-1:0] lt_n, gt_n, eq_n, run_cur_n, run_max_n;
  logic [CNT_W-1:0] lt_q, gt_q, eq_q, run_q;
`ifdef CMP_TRK_ERR_CHECK_EN
  logic [CNT_W-1:0] err_acc, err_n, err_q;
`endif

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(32'(v), CNT_W));
  endfunction

  cmp_flag_decode u_dec (
    .lesser  (bus.in_lesser),
    .greater (bus.in_greater),
    .equal   (bus.in_equal),
    .cat     (cat)
  );

  assign ready  = (state == ACCUM);
  assign accept = bus.in_valid && ready;
  assign last   = (idx == IDX_W'(WINDOW - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // A completed report handshake with start set skips IDLE entirely.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = ACCUM;
      ACCUM:   if (accept && last) state_n = REPORT;
      REPORT:  if (bus.rpt_ready) state_n = bus.start ? ACCUM : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next accumulator values; also feed the snapshot so the final sample is included.
  always_comb begin
    lt_n      = lt_acc;
    gt_n      = gt_acc;
    eq_n      = eq_acc;
    run_cur_n = run_cur;
    run_max_n = run_max;
`ifdef CMP_TRK_ERR_CHECK_EN
    err_n     = err_acc;
`endif
    if (accept) begin
      run_cur_n = '0;
      case (cat)
        CAT_LT: lt_n = inc(lt_acc);
        CAT_GT: gt_n = inc(gt_acc);
        CAT_EQ: begin
          eq_n      = inc(eq_acc);
          run_cur_n = inc(run_cur);
        end
`ifdef CMP_TRK_ERR_CHECK_EN
        CAT_ERR: err_n = inc(err_acc);
`endif
        default: ;
      endcase
      if (run_cur_n > run_max) run_max_n = run_cur_n;
    end
  end

  // Accumulators sit cleared outside ACCUM, so every new window starts from zero.
  always_ff @(posedge clk) begin
    if (rst || state != ACCUM) begin
      idx     <= '0;
      lt_acc  <= '0;
      gt_acc  <= '0;
      eq_acc  <= '0;
      run_cur <= '0;
      run_max <= '0;
`ifdef CMP_TRK_ERR_CHECK_EN
      err_acc <= '0;
`endif
    end else if (accept) begin
      idx     <= idx + 1'b1;
      lt_acc  <= lt_n;
      gt_acc  <= gt_n;
      eq_acc  <= eq_n;
      run_cur <= run_cur_n;
      run_max <= run_max_n;
`ifdef CMP_TRK_ERR_CHECK_EN
      err_acc <= err_n;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lt_q  <= '0;
      gt_q  <= '0;
      eq_q  <= '0;
      run_q <= '0;
`ifdef CMP_TRK_ERR_CHECK_EN
      err_q <= '0;
`endif
    end else if (accept && last) begin
      lt_q  <= lt_n;
      gt_q  <= gt_n;
      eq_q  <= eq_n;
      run_q <= run_max_n;
`ifdef CMP_TRK_ERR_CHECK_EN
      err_q <= err_n;
`endif
    end
  end

  assign bus.in_ready   = ready;
  assign bus.rpt_valid  = (state == REPORT);
  assign bus.busy       = (state != IDLE);
  assign bus.lt_cnt     = lt_q;
  assign bus.gt_cnt     = gt_q;
  assign bus.eq_cnt     = eq_q;
  assign bus.eq_run_max = run_q;
`ifdef CMP_TRK_ERR_CHECK_EN
  assign bus.err_cnt    = err_q;
`else
  assign bus.err_cnt    = '0;
`endif

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Scoreboard bench for cmp_result_tracker across three WINDOW/CNT_W configurations.
module tb_cmp_result_tracker;

  typedef struct {
    int lt;
    int gt;
    int eq;
    int mx;
    int err;
  } rpt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   sel = 0;
  logic drvStart = 1'b0, drvValid = 1'b0, drvRptReady = 1'b0;
  logic drvL = 1'b0, drvG = 1'b0, drvE = 1'b0;

  logic [7:0] obsLt, obsGt, obsEq, obsMax, obsErr;
  logic       obsInReady, obsRptValid, obsBusy;

  int   testsRun = 0;
  int   testsFailed = 0;
  rpt_t sb[$];
  int   mLt = 0, mGt = 0, mEq = 0, mRun = 0, mMax = 0, mErr = 0, mIdx = 0;

  always #5 clk = ~clk;

  cmp_result_tracker_if #(.CNT_W(8)) if0 ();
  cmp_result_tracker_if #(.CNT_W(8)) if1 ();
  cmp_result_tracker_if #(.CNT_W(2)) if2 ();

  cmp_result_tracker #(.WINDOW(4), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(if0));
  cmp_result_tracker #(.WINDOW(6), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(if1));
  cmp_result_tracker #(.WINDOW(6), .CNT_W(2)) u2 (.clk(clk), .rst(rst), .bus(if2));

  // Only the selected instance sees start/valid/ready; the others stay idle.
  assign if0.start = (sel == 0) && drvStart;
  assign if1.start = (sel == 1) && drvStart;
  assign if2.start = (sel == 2) && drvStart;
  assign if0.in_valid = (sel == 0) && drvValid;
  assign if1.in_valid = (sel == 1) && drvValid;
  assign if2.in_valid = (sel == 2) && drvValid;
  assign if0.rpt_ready = (sel == 0) && drvRptReady;
  assign if1.rpt_ready = (sel == 1) && drvRptReady;
  assign if2.rpt_ready = (sel == 2) && drvRptReady;
  assign {if0.in_lesser, if0.in_greater, if0.in_equal} = {drvL, drvG, drvE};
  assign {if1.in_lesser, if1.in_greater, if1.in_equal} = {drvL, drvG, drvE};
  assign {if2.in_lesser, if2.in_greater, if2.in_equal} = {drvL, drvG, drvE};

  always_comb begin
    case (sel)
      1: begin
        obsLt = if1.lt_cnt; obsGt = if1.gt_cnt; obsEq = if1.eq_cnt;
        obsMax = if1.eq_run_max; obsErr = if1.err_cnt;
        obsInReady = if1.in_ready; obsRptValid = if1.rpt_valid; obsBusy = if1.busy;
      end
      2: begin
        obsLt = 8'(if2.lt_cnt); obsGt = 8'(if2.gt_cnt); obsEq = 8'(if2.eq_cnt);
        obsMax = 8'(if2.eq_run_max); obsErr = 8'(if2.err_cnt);
        obsInReady = if2.in_ready; obsRptValid = if2.rpt_valid; obsBusy = if2.busy;
      end
      default: begin
        obsLt = if0.lt_cnt; obsGt = if0.gt_cnt; obsEq = if0.eq_cnt;
        obsMax = if0.eq_run_max; obsErr = if0.err_cnt;
        obsInReady = if0.in_ready; obsRptValid = if0.rpt_valid; obsBusy = if0.busy;
      end
    endcase
  end

  function automatic int curWin();
    return (sel == 0) ? 4 : 6;
  endfunction

  function automatic int curMax();
    return (sel == 2) ? 3 : 255;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelClear();
    mLt = 0; mGt = 0; mEq = 0; mRun = 0; mMax = 0; mErr = 0; mIdx = 0;
  endtask

  task automatic modelSample(input logic l, input logic g, input logic e);
    int   mx = curMax();
    logic isLt, isGt, isEq, isErr;
`ifdef CMP_TRK_ERR_CHECK_EN
    isErr = !({l, g, e} inside {3'b100, 3'b010, 3'b001});
    isLt  = l && !isErr;
    isGt  = g && !isErr;
    isEq  = e && !isErr;
`else
    isErr = 1'b0;
    isLt  = l;
    isGt  = g && !l;
    isEq  = e && !l && !g;
`endif
    if (isLt)  mLt  = (mLt  < mx) ? mLt  + 1 : mx;
    if (isGt)  mGt  = (mGt  < mx) ? mGt  + 1 : mx;
    if (isEq)  mEq  = (mEq  < mx) ? mEq  + 1 : mx;
    if (isErr) mErr = (mErr < mx) ? mErr + 1 : mx;
    mRun = isEq ? ((mRun < mx) ? mRun + 1 : mx) : 0;
    if (mRun > mMax) mMax = mRun;
    mIdx++;
    if (mIdx == curWin()) begin
      sb.push_back('{lt: mLt, gt: mGt, eq: mEq, mx: mMax, err: mErr});
      modelClear();
    end
  endtask

  task automatic startWindow();
    drvStart = 1'b1;
    @(posedge clk); #1;
    drvStart = 1'b0;
    modelClear();
    checkOutput("start_in_ready", obsInReady, 1);
  endtask

  // Presents one sample and holds it until the DUT accepts it.
  task automatic applyStimulus(input logic l, input logic g, input logic e);
    int budget = 20;
    drvL = l; drvG = g; drvE = e; drvValid = 1'b1;
    while (!obsInReady && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!obsInReady) begin
      drvValid = 1'b0;
      checkOutput("accept_timeout", 0, 1);
      return;
    end
    @(posedge clk); #1;
    drvValid = 1'b0;
    modelSample(l, g, e);
  endtask

  task automatic collectReport(input logic withStart);
    int   budget = 20;
    rpt_t exp;
    while (!obsRptValid && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!obsRptValid) begin
      checkOutput("rpt_timeout", 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      checkOutput("sb_underflow", 0, 1);
      return;
    end
    exp = sb.pop_front();
    checkOutput("lt_cnt", obsLt, exp.lt);
    checkOutput("gt_cnt", obsGt, exp.gt);
    checkOutput("eq_cnt", obsEq, exp.eq);
    checkOutput("eq_run_max", obsMax, exp.mx);
    checkOutput("err_cnt", obsErr, exp.err);
    drvRptReady = 1'b1;
    drvStart = withStart;
    @(posedge clk); #1;
    drvRptReady = 1'b0;
    drvStart = 1'b0;
    if (withStart) modelClear();
    checkOutput("rpt_valid_drop", obsRptValid, 0);
    checkOutput("in_ready_after_rpt", obsInReady, withStart);
  endtask

  initial begin
    // Reset and idle behaviour.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      checkOutput("rst_rpt_valid", obsRptValid, 0);
      checkOutput("rst_in_ready", obsInReady, 0);
      checkOutput("rst_busy", obsBusy, 0);
      checkOutput("rst_counts", {obsLt, obsGt, obsEq, obsMax}, 0);
      checkOutput("rst_err", obsErr, 0);
    end
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      drvValid = i[0]; drvE = 1'b1;
      @(posedge clk); #1;
      checkOutput("idle_in_ready", obsInReady, 0);
    end
    drvValid = 1'b0; drvE = 1'b0;
    checkOutput("idle_eq_cnt", obsEq, 0);

    // Basic window with report latency.
    startWindow();
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 0);
    checkOutput("rpt_latency", obsRptValid, 1);
    collectReport(0);

    // Backpressure: report held, start and samples ignored, then restart on handshake.
    startWindow();
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      drvValid = 1'b1; drvE = 1'b1; drvStart = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_rpt_valid", obsRptValid, 1);
      checkOutput("bp_in_ready", obsInReady, 0);
      checkOutput("bp_eq_cnt", obsEq, sb[0].eq);
      checkOutput("bp_run_max", obsMax, sb[0].mx);
    end
    drvValid = 1'b0; drvE = 1'b0; drvStart = 1'b0;
    collectReport(1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0);
    collectReport(0);

    // Non-one-hot flags on sample 2.
    startWindow();
    applyStimulus(0, 0, 1);
    applyStimulus(1, 1, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    collectReport(0);

    // Reset in the middle of a window.
    startWindow();
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    modelClear();
    checkOutput("midrst_in_ready", obsInReady, 0);
    checkOutput("midrst_busy", obsBusy, 0);
    checkOutput("midrst_lt_cnt", obsLt, 0);
    drvValid = 1'b1; drvE = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    drvValid = 1'b0; drvE = 1'b0;
    checkOutput("midrst_rpt_valid", obsRptValid, 0);
    checkOutput("midrst_eq_cnt", obsEq, 0);

    // Run tracking on the WINDOW=6 instance.
    sel = 1; #1;
    startWindow();
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    collectReport(0);

    // Saturation on the CNT_W=2 instance.
    sel = 2; #1;
    startWindow();
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1);
    collectReport(0);

    checkOutput("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
